uart_rx_sampler: RTL and testbench

//  Serial front end of the UART receiver, upstream of the RX controller FSM.
//  - Synchronises the raw rx line and detects the start-bit falling edge.
//  - Samples each bit at mid-bit, using a 3-sample majority vote on a 16x oversample tick.
//  - Delivers start_bit, per-bit strobes and data to the RX controller, shift register and parity checker.
//  - Flags false starts and framing (stop-bit) errors.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler_if.sv | 33 +++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_sampler.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: sampler FSM encoding, bit-kind codes,
// default frame geometry and the majority-vote helper.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] KIND_DATA   = 2'd0;
  localparam logic [1:0] KIND_PARITY = 2'd1;
  localparam logic [1:0] KIND_STOP   = 2'd2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Bit-level result bus from the RX sampler to the RX controller, shift
// register and parity checker.
interface uart_rx_sampler_if;

  logic       start_bit;
  logic       bit_valid;
  logic       bit_data;
  logic [1:0] bit_kind;
  logic       frame_active;
  logic       false_start;
  logic       framing_error;

  modport master (
    output start_bit,
    output bit_valid,
    output bit_data,
    output bit_kind,
    output frame_active,
    output false_start,
    output framing_error
  );

  modport slave (
    input start_bit,
    input bit_valid,
    input bit_data,
    input bit_kind,
    input frame_active,
    input false_start,
    input framing_error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx line plus one extra flop so a
// falling edge can be seen as (older 1, newer 0).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_edge
);

  localparam int STAGES = 3;

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d[0] = rx_in;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_chain
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  // Reset to all ones so a line that idles high never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s      = sync_q[1];
  assign fall_edge = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start-edge detection, mid-bit 3-sample majority
// voting on the oversample tick, and per-bit strobes with framing checks.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               baud_tick,
  input  logic               rx_in,
  uart_rx_sampler_if.master  rx_if
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H  = OVERSAMPLE / 2;

  localparam logic [SW-1:0] SC_VOTE0  = SW'(H - 1);
  localparam logic [SW-1:0] SC_VOTE1  = SW'(H);
  localparam logic [SW-1:0] SC_DECIDE = SW'(H + 1);
  localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST   = BW'(DATA_BITS - 1);

  logic rx_s;
  logic fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  rx_state_e     state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    vote_q, vote_d;
  logic          bit_data_q, bit_data_d;
  logic [1:0]    bit_kind_q, bit_kind_d;
  logic          frame_active_q, frame_active_d;

  logic          start_bit_c;
  logic          bit_valid_c;
  logic          false_start_c;
  logic          framing_error_c;
  logic [1:0]    kind_c;

  logic          in_frame;
  logic          decide;
  logic          vote_now;

  assign in_frame = (state_q != ST_IDLE);
  assign decide   = baud_tick && in_frame && (scnt_q == SC_DECIDE);
  assign vote_now = maj3(vote_q[0], vote_q[1], rx_s);

  always_comb begin
    state_d         = state_q;
    scnt_d          = scnt_q;
    bcnt_d          = bcnt_q;
    vote_d          = vote_q;
    bit_data_d      = bit_data_q;
    bit_kind_d      = bit_kind_q;
    frame_active_d  = frame_active_q;
    start_bit_c     = 1'b0;
    bit_valid_c     = 1'b0;
    false_start_c   = 1'b0;
    framing_error_c = 1'b0;
    kind_c          = KIND_DATA;

    // Sample counter and the two early vote samples only run inside a frame.
    if (baud_tick && in_frame) begin
      scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + 1'b1;
      if (scnt_q == SC_VOTE0) vote_d[0] = rx_s;
      if (scnt_q == SC_VOTE1) vote_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          scnt_d         = '0;
          state_d        = ST_START;
          frame_active_d = 1'b1;
        end
      end
      ST_START: begin
        if (decide) begin
          if (!vote_now) begin
            start_bit_c = 1'b1;
            bcnt_d      = '0;
            state_d     = ST_DATA;
          end else begin
            false_start_c  = 1'b1;
            scnt_d         = '0;
            frame_active_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          bit_valid_c = 1'b1;
          kind_c      = KIND_DATA;
          bcnt_d      = bcnt_q + 1'b1;
          if (bcnt_q == BC_LAST) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          bit_valid_c = 1'b1;
          kind_c      = KIND_PARITY;
          state_d     = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (decide) begin
          bit_valid_c     = 1'b1;
          kind_c          = KIND_STOP;
          framing_error_c = ~vote_now;
          scnt_d          = '0;
          frame_active_d  = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bit_valid_c) begin
      bit_data_d = vote_now;
      bit_kind_d = kind_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      scnt_q         <= '0;
      bcnt_q         <= '0;
      vote_q         <= '0;
      bit_data_q     <= 1'b0;
      bit_kind_q     <= KIND_DATA;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      scnt_q         <= scnt_d;
      bcnt_q         <= bcnt_d;
      vote_q         <= vote_d;
      bit_data_q     <= bit_data_d;
      bit_kind_q     <= bit_kind_d;
      frame_active_q <= frame_active_d;
    end
  end

  // Strobes are decided in the tick cycle itself; bit_data/bit_kind show the
  // fresh vote alongside bit_valid and hold it afterwards.
  assign rx_if.start_bit     = start_bit_c & ~reset;
  assign rx_if.bit_valid     = bit_valid_c & ~reset;
  assign rx_if.false_start   = false_start_c & ~reset;
  assign rx_if.framing_error = framing_error_c & ~reset;
  assign rx_if.bit_data      = bit_data_d & ~reset;
  assign rx_if.bit_kind      = reset ? KIND_DATA : bit_kind_d;
  assign rx_if.frame_active  = frame_active_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: scoreboarded bit strobes for an
// 8-bit parity instance and a 7-bit no-parity instance.
module tb_uart_rx_sampler;

  typedef struct {
    logic [1:0] kind;
    logic       data;
  } exp_t;

  logic clk;
  logic reset;
  logic baud_tick;
  logic rx1;
  logic rx2;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 4;
  int tick_phase = 0;

  int st1 = 0, fs1 = 0, fe1 = 0, bv1 = 0;
  int st2 = 0, fs2 = 0, fe2 = 0, bv2 = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic efe1, efe2;

  uart_rx_sampler_if if1();
  uart_rx_sampler_if if2();

  uart_rx_sampler #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx1), .rx_if(if1)
  );

  uart_rx_sampler #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx2), .rx_if(if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase = (tick_phase + 1) % tick_div;
      baud_tick  = (tick_phase == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor, 8-bit parity instance.
  always @(negedge clk) begin
    if (!reset) begin
      if ((if1.start_bit || if1.bit_valid || if1.false_start || if1.framing_error) && !baud_tick) begin
        n_checks++; n_fail++;
        $display("FAIL pulse_on_tick dut1: pulse at %0t with baud_tick=0, required 1", $time);
      end
      if (if1.start_bit)     st1++;
      if (if1.false_start)   fs1++;
      if (if1.framing_error) fe1++;
      if (if1.bit_valid) begin
        bv1++; n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL bit_valid dut1: unexpected bit kind=%0d data=%0b, required none", if1.bit_kind, if1.bit_data);
        end else begin
          e1   = q1.pop_front();
          efe1 = (e1.kind == 2'd2) && !e1.data;
          if ({if1.bit_kind, if1.bit_data, if1.framing_error} !== {e1.kind, e1.data, efe1}) begin
            n_fail++;
            $display("FAIL bit dut1: got kind=%0d data=%0b ferr=%0b, required kind=%0d data=%0b ferr=%0b",
                     if1.bit_kind, if1.bit_data, if1.framing_error, e1.kind, e1.data, efe1);
          end else begin
            $display("bit dut1: kind=%0d data=%0b ferr=%0b ok", if1.bit_kind, if1.bit_data, if1.framing_error);
          end
        end
      end else if (if1.framing_error) begin
        n_checks++; n_fail++;
        $display("FAIL framing_error dut1: pulse without bit_valid, required 0");
      end
    end
  end

  // Scoreboard monitor, 7-bit no-parity instance.
  always @(negedge clk) begin
    if (!reset) begin
      if ((if2.start_bit || if2.bit_valid || if2.false_start || if2.framing_error) && !baud_tick) begin
        n_checks++; n_fail++;
        $display("FAIL pulse_on_tick dut2: pulse at %0t with baud_tick=0, required 1", $time);
      end
      if (if2.start_bit)     st2++;
      if (if2.false_start)   fs2++;
      if (if2.framing_error) fe2++;
      if (if2.bit_valid) begin
        bv2++; n_checks++;
        if (q2.size() == 0) begin
          n_fail++;
          $display("FAIL bit_valid dut2: unexpected bit kind=%0d data=%0b, required none", if2.bit_kind, if2.bit_data);
        end else begin
          e2   = q2.pop_front();
          efe2 = (e2.kind == 2'd2) && !e2.data;
          if ({if2.bit_kind, if2.bit_data, if2.framing_error} !== {e2.kind, e2.data, efe2}) begin
            n_fail++;
            $display("FAIL bit dut2: got kind=%0d data=%0b ferr=%0b, required kind=%0d data=%0b ferr=%0b",
                     if2.bit_kind, if2.bit_data, if2.framing_error, e2.kind, e2.data, efe2);
          end else begin
            $display("bit dut2: kind=%0d data=%0b ferr=%0b ok", if2.bit_kind, if2.bit_data, if2.framing_error);
          end
        end
      end else if (if2.framing_error) begin
        n_checks++; n_fail++;
        $display("FAIL framing_error dut2: pulse without bit_valid, required 0");
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx1 = v;
  endtask

  task automatic push_exp(input bit sel, input logic [1:0] kind, input logic data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    if (sel) q2.push_back(e);
    else     q1.push_back(e);
  endtask

  // Drives one frame LSB first; the line is left at the stop value.
  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic stop_val);
    logic p;
    p = 1'b0;
    set_line(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      push_exp(sel, 2'd0, data[i]);
      p = p ^ data[i];
      wait_ticks(16);
    end
    if (par_en) begin
      set_line(sel, p);
      push_exp(sel, 2'd1, p);
      wait_ticks(16);
    end
    set_line(sel, stop_val);
    push_exp(sel, 2'd2, stop_val);
    wait_ticks(16);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 7;
    if (if1.start_bit !== 1'b0)     begin n_fail++; $display("FAIL reset start_bit: got %0b, required 0", if1.start_bit); end
    if (if1.bit_valid !== 1'b0)     begin n_fail++; $display("FAIL reset bit_valid: got %0b, required 0", if1.bit_valid); end
    if (if1.bit_data !== 1'b0)      begin n_fail++; $display("FAIL reset bit_data: got %0b, required 0", if1.bit_data); end
    if (if1.bit_kind !== 2'd0)      begin n_fail++; $display("FAIL reset bit_kind: got %0d, required 0", if1.bit_kind); end
    if (if1.frame_active !== 1'b0)  begin n_fail++; $display("FAIL reset frame_active: got %0b, required 0", if1.frame_active); end
    if (if1.false_start !== 1'b0)   begin n_fail++; $display("FAIL reset false_start: got %0b, required 0", if1.false_start); end
    if (if1.framing_error !== 1'b0) begin n_fail++; $display("FAIL reset framing_error: got %0b, required 0", if1.framing_error); end
    $display("test_reset: outputs checked");
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ticks(8);
  endtask

  task automatic test_frame_a5();
    int s0, f0, e0, b0;
    s0 = st1; f0 = fs1; e0 = fe1; b0 = bv1;
    send_frame(1'b0, 9'h0A5, 8, 1'b1, 1'b1);
    wait_ticks(4);
    n_checks += 4;
    if (st1 - s0 !== 1)  begin n_fail++; $display("FAIL a5 start_bit count: got %0d, required 1", st1 - s0); end
    if (bv1 - b0 !== 10) begin n_fail++; $display("FAIL a5 bit_valid count: got %0d, required 10", bv1 - b0); end
    if ((fs1 - f0) + (fe1 - e0) !== 0) begin n_fail++; $display("FAIL a5 errors: got %0d, required 0", (fs1 - f0) + (fe1 - e0)); end
    if (q1.size() !== 0) begin n_fail++; $display("FAIL a5 scoreboard: %0d left, required 0", q1.size()); end
    $display("test_frame_a5: done");
  endtask

  task automatic test_false_start();
    int s0, f0, b0;
    s0 = st1; f0 = fs1; b0 = bv1;
    set_line(1'b0, 1'b0);
    wait_ticks(5);
    set_line(1'b0, 1'b1);
    wait_ticks(20);
    n_checks += 4;
    if (fs1 - f0 !== 1) begin n_fail++; $display("FAIL glitch false_start count: got %0d, required 1", fs1 - f0); end
    if (st1 - s0 !== 0) begin n_fail++; $display("FAIL glitch start_bit count: got %0d, required 0", st1 - s0); end
    if (bv1 - b0 !== 0) begin n_fail++; $display("FAIL glitch bit_valid count: got %0d, required 0", bv1 - b0); end
    if (if1.frame_active !== 1'b0) begin n_fail++; $display("FAIL glitch frame_active: got %0b, required 0", if1.frame_active); end
    $display("test_false_start: done");
  endtask

  task automatic test_framing_break();
    int s0, f0, e0;
    s0 = st1; f0 = fs1; e0 = fe1;
    send_frame(1'b0, 9'h03C, 8, 1'b1, 1'b0);
    wait_ticks(32);
    n_checks += 4;
    if (fe1 - e0 !== 1) begin n_fail++; $display("FAIL break framing_error count: got %0d, required 1", fe1 - e0); end
    if (st1 - s0 !== 1) begin n_fail++; $display("FAIL break start_bit count: got %0d, required 1", st1 - s0); end
    if (fs1 - f0 !== 0) begin n_fail++; $display("FAIL break false_start count: got %0d, required 0", fs1 - f0); end
    if (if1.frame_active !== 1'b0) begin n_fail++; $display("FAIL break frame_active: got %0b, required 0", if1.frame_active); end
    set_line(1'b0, 1'b1);
    wait_ticks(16);
    $display("test_framing_break: done");
  endtask

  task automatic test_back_to_back();
    int s0, b0, e0;
    s0 = st1; b0 = bv1; e0 = fe1;
    send_frame(1'b0, 9'h055, 8, 1'b1, 1'b1);
    send_frame(1'b0, 9'h0FF, 8, 1'b1, 1'b1);
    wait_ticks(8);
    n_checks += 4;
    if (bv1 - b0 !== 20) begin n_fail++; $display("FAIL b2b bit_valid count: got %0d, required 20", bv1 - b0); end
    if (st1 - s0 !== 2)  begin n_fail++; $display("FAIL b2b start_bit count: got %0d, required 2", st1 - s0); end
    if (fe1 - e0 !== 0)  begin n_fail++; $display("FAIL b2b framing_error count: got %0d, required 0", fe1 - e0); end
    if (q1.size() !== 0) begin n_fail++; $display("FAIL b2b scoreboard: %0d left, required 0", q1.size()); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int s0, f0, e0, b0;
    d = 8'h0F;
    set_line(1'b0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      set_line(1'b0, d[i]);
      push_exp(1'b0, 2'd0, d[i]);
      wait_ticks(16);
    end
    set_line(1'b0, d[3]);
    wait_ticks(4);
    n_checks += 2;
    if (if1.frame_active !== 1'b1) begin n_fail++; $display("FAIL midframe frame_active: got %0b, required 1", if1.frame_active); end
    if (if1.bit_data !== 1'b1)     begin n_fail++; $display("FAIL midframe held bit_data: got %0b, required 1", if1.bit_data); end
    reset = 1'b1;
    set_line(1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (if1.frame_active !== 1'b0) begin n_fail++; $display("FAIL abort frame_active: got %0b, required 0", if1.frame_active); end
    if (if1.bit_data !== 1'b0)     begin n_fail++; $display("FAIL abort bit_data: got %0b, required 0", if1.bit_data); end
    if (if1.bit_kind !== 2'd0)     begin n_fail++; $display("FAIL abort bit_kind: got %0d, required 0", if1.bit_kind); end
    if (q1.size() !== 0)           begin n_fail++; $display("FAIL abort scoreboard: %0d left, required 0", q1.size()); end
    s0 = st1; f0 = fs1; e0 = fe1; b0 = bv1;
    wait_ticks(40);
    n_checks += 1;
    if ((st1 - s0) + (fs1 - f0) + (fe1 - e0) + (bv1 - b0) !== 0) begin
      n_fail++; $display("FAIL abort quiet: got %0d pulses, required 0", (st1 - s0) + (fs1 - f0) + (fe1 - e0) + (bv1 - b0));
    end
    s0 = st1; b0 = bv1;
    send_frame(1'b0, 9'h081, 8, 1'b1, 1'b1);
    wait_ticks(4);
    n_checks += 2;
    if (st1 - s0 !== 1)  begin n_fail++; $display("FAIL post-abort start_bit: got %0d, required 1", st1 - s0); end
    if (bv1 - b0 !== 10) begin n_fail++; $display("FAIL post-abort bit_valid: got %0d, required 10", bv1 - b0); end
    $display("test_reset_mid_frame: done");
  endtask

  task automatic test_continuous_tick();
    int s0, b0;
    s0 = st1; b0 = bv1;
    tick_div = 1;
    wait_ticks(4);
    send_frame(1'b0, 9'h05A, 8, 1'b1, 1'b1);
    wait_ticks(4);
    tick_div = 4;
    wait_ticks(4);
    n_checks += 2;
    if (st1 - s0 !== 1)  begin n_fail++; $display("FAIL cont_tick start_bit: got %0d, required 1", st1 - s0); end
    if (bv1 - b0 !== 10) begin n_fail++; $display("FAIL cont_tick bit_valid: got %0d, required 10", bv1 - b0); end
    $display("test_continuous_tick: done");
  endtask

  task automatic test_no_parity();
    int s0, b0, e0;
    s0 = st2; b0 = bv2; e0 = fe2;
    send_frame(1'b1, 9'h07F, 7, 1'b0, 1'b1);
    wait_ticks(4);
    n_checks += 4;
    if (bv2 - b0 !== 8)  begin n_fail++; $display("FAIL nopar bit_valid count: got %0d, required 8", bv2 - b0); end
    if (st2 - s0 !== 1)  begin n_fail++; $display("FAIL nopar start_bit count: got %0d, required 1", st2 - s0); end
    if (fe2 - e0 !== 0)  begin n_fail++; $display("FAIL nopar framing_error count: got %0d, required 0", fe2 - e0); end
    if (q2.size() !== 0) begin n_fail++; $display("FAIL nopar scoreboard: %0d left, required 0", q2.size()); end
    $display("test_no_parity: done");
  endtask

  initial begin
    reset = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    test_reset();
    test_frame_a5();
    test_false_start();
    test_framing_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_continuous_tick();
    test_no_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
